// File: rtl/in_fm_tile_scheduler.sv
// Walks one input-feature-map layer tile by tile (col, then row, then channel),
// pacing mover transfers against the free input-buffer credits.
module in_fm_tile_scheduler #(
   parameter int AW   = 32,
   parameter int M    = 32,
   parameter int R    = 64,
   parameter int C    = 32,
   parameter int Tm   = 8,
   parameter int Tr   = 16,
   parameter int Tc   = 8,
   parameter int NBUF = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   output logic          done,
   output logic          busy,
   output logic          tile_start,
   input  logic          tile_done,
   output logic [AW-1:0] tile_base_m,
   output logic [AW-1:0] tile_base_row,
   output logic [AW-1:0] tile_base_col,
   input  logic          tile_consumed,
   output logic [3:0]    credits
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FIN} state_t;

   state_t        r_state;
   logic [AW-1:0] r_m;
   logic [AW-1:0] r_row;
   logic [AW-1:0] r_col;
   logic [3:0]    r_credits;
   logic          r_done;
   logic          r_busy;
   logic          r_tile_start;

   logic          w_col_wrap;
   logic          w_row_wrap;
   logic          w_m_wrap;
   logic          w_last;
   logic          w_issue;

   // A counter is at its final value when the next step would reach or pass the edge.
   assign w_col_wrap = (r_col + AW'(Tc)) >= AW'(C);
   assign w_row_wrap = (r_row + AW'(Tr)) >= AW'(R);
   assign w_m_wrap   = (r_m + AW'(Tm)) >= AW'(M);
   assign w_last     = w_col_wrap && w_row_wrap && w_m_wrap;
   assign w_issue    = (r_state == S_ISSUE) && (r_credits != 4'd0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_m          <= '0;
         r_row        <= '0;
         r_col        <= '0;
         r_credits    <= 4'(NBUF);
         r_done       <= 1'b0;
         r_busy       <= 1'b0;
         r_tile_start <= 1'b0;
      end else begin
         r_done       <= 1'b0;
         r_tile_start <= 1'b0;

         // An issue and a freed buffer in the same cycle cancel out.
         if (w_issue && !tile_consumed)
            r_credits <= r_credits - 4'd1;
         else if (!w_issue && tile_consumed && (r_credits < 4'(NBUF)))
            r_credits <= r_credits + 4'd1;

         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state <= S_ISSUE;
                  r_busy  <= 1'b1;
                  r_m     <= '0;
                  r_row   <= '0;
                  r_col   <= '0;
               end
            end
            S_ISSUE: begin
               if (w_issue) begin
                  r_tile_start <= 1'b1;
                  r_state      <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (tile_done) begin
                  if (w_last) begin
                     r_state <= S_FIN;
                     r_done  <= 1'b1;
                     r_busy  <= 1'b0;
                  end else begin
                     r_state <= S_ISSUE;
                     if (w_col_wrap) begin
                        r_col <= '0;
                        if (w_row_wrap) begin
                           r_row <= '0;
                           r_m   <= r_m + AW'(Tm);
                        end else begin
                           r_row <= r_row + AW'(Tr);
                        end
                     end else begin
                        r_col <= r_col + AW'(Tc);
                     end
                  end
               end
            end
            S_FIN:   r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign done          = r_done;
   assign busy          = r_busy;
   assign tile_start    = r_tile_start;
   assign tile_base_m   = r_m;
   assign tile_base_row = r_row;
   assign tile_base_col = r_col;
   assign credits       = r_credits;

endmodule
